// File: rtl/io_tx_port.sv
// CPU OUT-port peripheral: byte FIFO feeding an 8N1 serial transmitter.
// Writes never stall; a write to a full FIFO is dropped and flagged in overflow.
//
// state   | meaning
// S_IDLE  | line high, waiting for a buffered byte
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit (high); chains straight into the next frame if data waits
module io_tx_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic [7:0] io_data,
  input  logic       io_write,
  input  logic       clear_overflow,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]      CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [CW-1:0]      CYC_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  state_e             state_q, state_d;
  logic [CW-1:0]      cyc_q, cyc_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               pop, push, drop, full, cyc_last, have_data;

  assign full      = (count_q == DEPTH_C);
  assign have_data = (count_q != '0);
  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push      = io_write && (!full || pop);
  assign drop      = io_write && full && !pop;
  assign cyc_last  = (cyc_q == CYC_LAST);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)                ovf_d = 1'b1;
    else if (clear_overflow) ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (have_data) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cyc_last) begin
          cyc_d   = '0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      S_DATA: begin
        if (cyc_last) begin
          cyc_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      S_STOP: begin
        if (cyc_last) begin
          cyc_d = '0;
          if (have_data) begin
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= io_data;
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE) || have_data;
  assign fifo_full = full;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_io_tx_port.sv
// Directed bench for io_tx_port with CLKS_PER_BIT=4, depth 4: frame table
// plus hand-written back-to-back, overflow, pop-on-full and reset sequences.
module tb_io_tx_port;

  logic       clk = 1'b0;
  logic       async_nreset = 1'b0;
  logic [7:0] io_data = 8'h00;
  logic       io_write = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       tx, busy, fifo_full, overflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected line per frame in time order: [9]=start, [8:1]=d0..d7, [0]=stop.
  logic [9:0] exp_fr [8];
  int         sch_k [$];
  logic [7:0] sch_d [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs [6];

  io_tx_port #(.CLKS_PER_BIT(4), .FIFO_AW(2)) dut (
    .clk            (clk),
    .async_nreset   (async_nreset),
    .io_data        (io_data),
    .io_write       (io_write),
    .clear_overflow (clear_overflow),
    .tx             (tx),
    .busy           (busy),
    .fifo_full      (fifo_full),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Cycle k counts from the pop edge of the first frame; scheduled writes
  // are driven during cycle k and captured at the edge that ends it.
  task automatic check_stream(input int k0, input int kend, input string nm, input bit chk_nf);
    for (int k = k0; k < kend; k++) begin
      io_write = 1'b0;
      if (sch_k.size() > 0 && sch_k[0] == k) begin
        void'(sch_k.pop_front());
        io_data  = sch_d.pop_front();
        io_write = 1'b1;
      end
      chk({nm, "_tx"}, tx, exp_fr[k / 40][9 - (k % 40) / 4]);
      chk({nm, "_busy"}, busy, 1'b1);
      if (chk_nf) chk({nm, "_full"}, fifo_full, 1'b0);
      tick();
    end
    io_write = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h00, 10'b0000000001};
    vecs[2] = '{8'hFF, 10'b0111111111};
    vecs[3] = '{8'h01, 10'b0100000001};
    vecs[4] = '{8'h80, 10'b0000000011};
    vecs[5] = '{8'h3C, 10'b0001111001};

    #12;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    @(negedge clk);
    async_nreset = 1'b1;
    tick();

    // Single frames: latency, exact bit timing, busy fall
    for (int i = 0; i < 6; i++) begin
      io_data  = vecs[i].data;
      io_write = 1'b1;
      tick();
      io_write = 1'b0;
      chk("lat_tx", tx, 1'b1);
      chk("lat_busy", busy, 1'b1);
      tick();
      exp_fr[0] = vecs[i].frame;
      check_stream(0, 40, "frame", 1'b0);
      chk("end_busy", busy, 1'b0);
      chk("end_tx", tx, 1'b1);
      chk("end_ovf", overflow, 1'b0);
      repeat (3) tick();
    end

    // Back-to-back 01,02,03 on consecutive edges
    exp_fr[0] = 10'b0100000001;
    exp_fr[1] = 10'b0010000001;
    exp_fr[2] = 10'b0110000001;
    io_data = 8'h01; io_write = 1'b1; tick();
    chk("b2b_full0", fifo_full, 1'b0);
    io_data = 8'h02; tick();
    sch_k.push_back(0); sch_d.push_back(8'h03);
    check_stream(0, 120, "b2b", 1'b1);
    chk("b2b_end_busy", busy, 1'b0);
    chk("b2b_end_ovf", overflow, 1'b0);
    repeat (3) tick();

    // Overflow: 10..15 on consecutive edges, with clear on the dropping edge
    exp_fr[0] = 10'b0000010001;
    exp_fr[1] = 10'b0100010001;
    exp_fr[2] = 10'b0010010001;
    exp_fr[3] = 10'b0110010001;
    exp_fr[4] = 10'b0001010001;
    io_data = 8'h10; io_write = 1'b1; tick();
    io_data = 8'h11; tick();
    chk("ovf_k0_tx", tx, 1'b0);
    io_data = 8'h12; tick();
    io_data = 8'h13; tick();
    chk("ovf_k2_full", fifo_full, 1'b0);
    io_data = 8'h14; tick();
    chk("ovf_k3_full", fifo_full, 1'b1);
    chk("ovf_k3_ovf", overflow, 1'b0);
    io_data = 8'h15; clear_overflow = 1'b1; tick();
    chk("ovf_set_prio", overflow, 1'b1);
    chk("ovf_k4_full", fifo_full, 1'b1);
    io_write = 1'b0; tick();
    chk("ovf_clear", overflow, 1'b0);
    chk("ovf_k5_full", fifo_full, 1'b1);
    clear_overflow = 1'b0;
    check_stream(5, 200, "ovf", 1'b0);
    chk("ovf_end_busy", busy, 1'b0);
    chk("ovf_end_full", fifo_full, 1'b0);
    repeat (3) tick();

    // Write on the last STOP cycle of a full FIFO: pop and push together
    exp_fr[0] = 10'b0000001001;
    exp_fr[1] = 10'b0100001001;
    exp_fr[2] = 10'b0010001001;
    exp_fr[3] = 10'b0110001001;
    exp_fr[4] = 10'b0001001001;
    exp_fr[5] = 10'b0111011101;
    io_data = 8'h20; io_write = 1'b1; tick();
    io_write = 1'b0; tick();
    sch_k = '{0, 1, 2, 3, 39};
    sch_d = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h77};
    check_stream(0, 40, "popfull", 1'b0);
    chk("popfull_full", fifo_full, 1'b1);
    chk("popfull_ovf", overflow, 1'b0);
    check_stream(40, 240, "popfull", 1'b0);
    chk("popfull_end_busy", busy, 1'b0);
    chk("popfull_end_ovf", overflow, 1'b0);
    repeat (3) tick();

    // Reset during DATA bit 3 of 0x55 with 0x66, 0x67 queued
    exp_fr[0] = 10'b0101010101;
    io_data = 8'h55; io_write = 1'b1; tick();
    io_write = 1'b0; tick();
    sch_k = '{0, 1};
    sch_d = '{8'h66, 8'h67};
    check_stream(0, 17, "prerst", 1'b0);
    #2;
    async_nreset = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_full", fifo_full, 1'b0);
    @(negedge clk);
    @(negedge clk);
    async_nreset = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      chk("postrst_tx", tx, 1'b1);
      chk("postrst_busy", busy, 1'b0);
    end

    // A fresh write after reset transmits normally
    exp_fr[0] = 10'b0001111001;
    io_data = 8'h3C; io_write = 1'b1; tick();
    io_write = 1'b0; tick();
    check_stream(0, 40, "recover", 1'b0);
    chk("recover_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_tx_port.md
# io_tx_port

Output-port peripheral on the CPU's I/O bus. Accepts each byte the CPU writes with its OUT instruction (the `io_data`/`io_write` strobe), buffers it in a small FIFO and serialises it on a UART-style 8N1 line. The CPU never stalls: OUT completes in one cycle, and overflow is flagged rather than back-pressured.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `FIFO_AW`, default 2: FIFO address width; depth = 2^FIFO_AW (default 4).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `async_nreset`  in  1  reset: asynchronous, active-low.
- `io_data`  in  8  byte from the CPU I/O data output.
- `io_write`  in  1  one-cycle write strobe from the CPU.
- `clear_overflow`  in  1  clears the `overflow` flag.
- `tx`  out  1  serial line; idle high; registered.
- `busy`  out  1  high when the FIFO is non-empty or a frame is in progress.
- `fifo_full`  out  1  FIFO count equals depth.
- `overflow`  out  1  sticky: a write was dropped.

## Operation
- Reset (asynchronous, immediate): `tx`=1, FIFO emptied (pointers and count = 0), `busy`=0, `fifo_full`=0, `overflow`=0, transmitter in IDLE.
- **FIFO write:** on an edge with `io_write`=1:
  - If not full, `io_data` is written at the tail.
  - If full, the byte is dropped and `overflow` is set.
  - Exception: a write on the same edge as a pop is accepted even when full. The pop frees the slot, so the count is unchanged.
- **Pointers:** wrap modulo depth. Count has width FIFO_AW+1.
- **`overflow` clearing:** cleared by `clear_overflow`=1. A set (dropped write) on the same edge takes priority over the clear.
- **Transmitter FSM:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If count > 0, pop the head into the shift register, clear the bit/cycle counters and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. The shift register shifts right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
    - If count > 0, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- **Counters:** cycle counter width is clog2(CLKS_PER_BIT) and counts 0..CLKS_PER_BIT-1; bit counter is 3 bits.
- **Outputs:**
  - `busy` = (state ≠ IDLE) or (count ≠ 0); combinational from registers.
  - `fifo_full` = (count == depth).
  - `tx` is driven from a register updated in the same edge as the state change, so the line is glitch-free.

## Timing
- **Write latency:** byte written at edge E into an empty FIFO with the FSM in IDLE → popped at edge E+1 → `tx` falls after E+1.
- **Frame length:** 10·CLKS_PER_BIT cycles. Back-to-back frames repeat every 10·CLKS_PER_BIT cycles exactly.
- **`fifo_full`:** reflects count after the edge. A write at the edge that fills the FIFO raises `fifo_full` in the following cycle.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronous), the partial frame is abandoned and buffered bytes are lost.
- **`io_write` held high:** each held cycle is a separate write. The CPU guarantees single-cycle strobes.

## Test plan
- **Single byte:** CLKS_PER_BIT=4, write 0xA5 at edge E.
  - Expected: `tx` low for cycles E+1..E+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles.
  - `busy` falls 40 cycles after E+1; `overflow`=0.
- **Back-to-back:** write 0x01, 0x02, 0x03 on consecutive edges.
  - Expected: three frames with no idle gap, total 120 cycles; `fifo_full` never asserts with depth 4.
- **Overflow:** write 6 bytes 0x10..0x15 on consecutive edges while idle.
  - Expected: 0x10 is popped at the 2nd edge; 0x14 fills the FIFO; 0x15 is dropped, so `overflow`=1.
  - Transmitted bytes: 0x10..0x14 only.
- **Write on full with pop:**
  - Setup: fill the FIFO during a frame, then write 0x77 on the exact last STOP cycle.
  - Expected: 0x77 accepted, `overflow` stays 0, count stays 4.
- **Overflow clear priority:** assert `clear_overflow` on the same edge as a dropped write.
  - Expected: `overflow` stays 1; clearing alone on the next edge → 0.
- **Reset mid-frame:** pull `async_nreset` low during DATA bit 3 with 2 bytes queued.
  - Expected: `tx`=1 within the same cycle, `busy`=0, no output after release until a new write.
